// File: rtl/reg_scan_pkg.sv
// Shared constants and FSM encoding for the register-file scan reader.
//   DATA_W   : register width
//   ADDR_W   : register address width
//   NUM_REGS : registers in the file (2**ADDR_W)
//   state_e  : scan FSM states, using the legacy 3-bit encodings
package reg_scan_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DRAIN0 = 3'd2;
  localparam logic [2:0] ST_DRAIN1 = 3'd3;
  localparam logic [2:0] ST_FIN    = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    FETCH  = ST_FETCH,
    DRAIN0 = ST_DRAIN0,
    DRAIN1 = ST_DRAIN1,
    FIN    = ST_FIN
  } state_e;

endpackage

// File: rtl/reg_scan_reader_if.sv
// Valid/ready stream carrying one {address, data} register word per handshake.
//   out_valid : word valid (master -> slave)
//   out_ready : downstream accepts (slave -> master)
//   out_addr  : register index of the word
//   out_data  : register contents
interface reg_scan_reader_if #(
  parameter int ADDR_W = reg_scan_pkg::ADDR_W,
  parameter int DATA_W = reg_scan_pkg::DATA_W
) ();

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_addr,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_addr,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/reg_file.sv
// NUM_REGS x DATA_W register file: one synchronous write port, two
// combinational read ports, contents cleared by asynchronous reset.
//   clk, rst_n             : clock, asynchronous active-low reset
//   we, write_reg, write_data : write port (takes effect at posedge)
//   read_reg1/read_data1   : read port 1
//   read_reg2/read_data2   : read port 2
module reg_file #(
  parameter int DATA_W   = reg_scan_pkg::DATA_W,
  parameter int ADDR_W   = reg_scan_pkg::ADDR_W,
  parameter int NUM_REGS = reg_scan_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  import reg_scan_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[write_reg] <= write_data;
    end
  end

  assign read_data1 = regs[read_reg1];
  assign read_data2 = regs[read_reg2];

endmodule

// File: rtl/reg_scan_reader.sv
// Sequential read-side master for the register file. On start it walks a
// contiguous, wrapping range of registers two at a time through read ports
// 1 and 2 and emits each register as an {address, data} stream word.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : begin a scan (honoured only when idle)
//   first_reg, count      : scan range, sampled with start (count clamps)
//   read_reg1/2           : register file read addresses (held outside FETCH)
//   read_data1/2          : register file read data (combinational)
//   stream                : {out_addr, out_data} valid/ready word stream
//   busy                  : scan in progress
//   done                  : one-cycle pulse at scan end
module reg_scan_reader #(
  parameter int DATA_W   = reg_scan_pkg::DATA_W,
  parameter int ADDR_W   = reg_scan_pkg::ADDR_W,
  parameter int NUM_REGS = reg_scan_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] read_reg1,
  output logic [ADDR_W-1:0] read_reg2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  reg_scan_reader_if.master stream,
  output logic              busy,
  output logic              done
);

  import reg_scan_pkg::*;

  localparam logic [ADDR_W:0] MAX_REM = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] REM_TWO = (ADDR_W+1)'(2);

  state_e            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W:0]   rem;
  logic [DATA_W-1:0] b0;
  logic [DATA_W-1:0] b1;
  logic [ADDR_W:0]   count_clamped;
  logic              handshake;

  assign count_clamped = (count > MAX_REM) ? MAX_REM : count;
  assign handshake     = stream.out_valid && stream.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      rem       <= '0;
      b0        <= '0;
      b1        <= '0;
      read_reg1 <= '0;
      read_reg2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur <= first_reg;
            rem <= count_clamped;
            if (count_clamped == '0) begin
              state <= FIN;
            end else begin
              // Read addresses are loaded on entry so they are valid
              // throughout the FETCH cycle itself.
              read_reg1 <= first_reg;
              read_reg2 <= first_reg + ADDR_W'(1);
              state     <= FETCH;
            end
          end
        end
        FETCH: begin
          b0    <= read_data1;
          b1    <= read_data2;
          state <= DRAIN0;
        end
        DRAIN0: begin
          if (handshake) begin
            if (rem == REM_ONE) begin
              rem   <= '0;
              state <= FIN;
            end else begin
              state <= DRAIN1;
            end
          end
        end
        DRAIN1: begin
          if (handshake) begin
            cur <= cur + ADDR_W'(2);
            rem <= rem - REM_TWO;
            if (rem == REM_TWO) begin
              state <= FIN;
            end else begin
              read_reg1 <= cur + ADDR_W'(2);
              read_reg2 <= cur + ADDR_W'(3);
              state     <= FETCH;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stream word is decoded from state and the pair buffer rather than kept
  // in separate registers; it is therefore stable for as long as the FSM
  // waits in a DRAIN state, and reads 0 straight out of reset.
  assign stream.out_valid = (state == DRAIN0) || (state == DRAIN1);
  assign stream.out_addr  = (state == DRAIN1) ? cur + ADDR_W'(1) : cur;
  assign stream.out_data  = (state == DRAIN1) ? b1 : b0;

  assign busy = (state != IDLE) && (state != FIN);
  assign done = (state == FIN);

endmodule

// File: tb/tb_reg_scan_reader.sv
module tb_reg_scan_reader;

  localparam int DW = reg_scan_pkg::DATA_W;
  localparam int AW = reg_scan_pkg::ADDR_W;
  localparam int NR = reg_scan_pkg::NUM_REGS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_reg = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] read_reg1, read_reg2;
  logic [DW-1:0] read_data1, read_data2;
  logic          busy, done;
  logic          we = 1'b0;
  logic [AW-1:0] write_reg = '0;
  logic [DW-1:0] write_data = '0;

  reg_scan_reader_if #(.ADDR_W(AW), .DATA_W(DW)) stream_if ();

  reg_scan_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .first_reg  (first_reg),
    .count      (count),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .stream     (stream_if),
    .busy       (busy),
    .done       (done)
  );

  reg_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) rf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]    model [NR];
  logic [AW+DW-1:0] got [$];
  logic [AW+DW-1:0] exp_q [$];
  int               done_c;
  int               done_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    write_reg  = AW'(a);
    write_data = d;
    we         = 1'b1;
    step();
    we         = 1'b0;
    model[a]   = d;
  endtask

  // Expected word list: min(count, NR) consecutive registers, wrapping.
  task automatic build_exp(input int first, input int cnt);
    int n;
    int a;
    exp_q.delete();
    n = (cnt > NR) ? NR : cnt;
    for (int i = 0; i < n; i++) begin
      a = (first + i) % NR;
      exp_q.push_back({AW'(a), model[a]});
    end
  endtask

  task automatic compare_words(input string tag);
    chk({tag, "_nwords"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_word%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    end
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready.
  // wr_c / restart_c: cycle (1 = FETCH cycle after start) for an injected
  // register write / ignored second start; 0 disables.
  task automatic run_scan(input string tag, input int first, input int cnt, input int mode,
                          input int wr_c, input int wr_a, input logic [DW-1:0] wr_d,
                          input int restart_c);
    int            c;
    int            n;
    int            exp_done;
    logic          stall;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic [3:0]    pat;
    pat = 4'b1001;
    got.delete();
    done_c = -1;
    done_n = 0;
    n = (cnt > NR) ? NR : cnt;
    exp_done = (n == 0) ? 1 : 1 + 3 * (n / 2) + 2 * (n % 2);
    first_reg = AW'(first);
    count     = (AW+1)'(cnt);
    start     = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    stall = 1'b0;
    pa = '0;
    pd = '0;
    while (c <= 200) begin
      if (c == 1) begin
        chk({tag, "_busy_c1"}, 64'(busy), 64'(n != 0));
        chk({tag, "_valid_c1"}, 64'(stream_if.out_valid), 64'(0));
        if (n != 0) begin
          chk({tag, "_rr1_c1"}, 64'(read_reg1), 64'(first % NR));
          chk({tag, "_rr2_c1"}, 64'(read_reg2), 64'((first + 1) % NR));
        end
      end
      if (stall) begin
        chk({tag, "_hold_valid"}, 64'(stream_if.out_valid), 64'(1));
        chk({tag, "_hold_addr"}, 64'(stream_if.out_addr), 64'(pa));
        chk({tag, "_hold_data"}, 64'(stream_if.out_data), 64'(pd));
      end
      we         = (c == wr_c);
      write_reg  = AW'(wr_a);
      write_data = wr_d;
      if (c == restart_c) begin
        start     = 1'b1;
        first_reg = AW'(first + 3);
        count     = (AW+1)'(2);
      end else begin
        start = 1'b0;
      end
      case (mode)
        0:       stream_if.out_ready = 1'b1;
        1:       stream_if.out_ready = pat[(c - 1) % 4];
        default: stream_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (done) begin
        done_c = c;
        done_n++;
      end
      if (stream_if.out_valid && stream_if.out_ready) begin
        got.push_back({stream_if.out_addr, stream_if.out_data});
      end
      stall = stream_if.out_valid && !stream_if.out_ready;
      pa = stream_if.out_addr;
      pd = stream_if.out_data;
      if (done_c >= 0) break;
      step();
      c++;
    end
    we    = 1'b0;
    start = 1'b0;
    stream_if.out_ready = 1'b1;
    chk({tag, "_done_seen"}, 64'(done_c >= 0), 64'(1));
    if (mode == 0) chk({tag, "_done_cycle"}, 64'(done_c), 64'(exp_done));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    step();
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    chk({tag, "_valid_after"}, 64'(stream_if.out_valid), 64'(0));
  endtask

  initial begin
    stream_if.out_ready = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // Reset state
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(stream_if.out_valid), 64'(0));
    chk("rst_addr", 64'(stream_if.out_addr), 64'(0));
    chk("rst_data", 64'(stream_if.out_data), 64'(0));
    chk("rst_rr1", 64'(read_reg1), 64'(0));
    chk("rst_rr2", 64'(read_reg2), 64'(0));
    step();
    rst_n = 1'b1;
    step();

    // Full scan
    for (int i = 0; i < NR; i++) wr(i, 32'h1111_1111 * i);
    build_exp(0, 8);
    run_scan("full", 0, 8, 0, 0, 0, '0, 0);
    compare_words("full");

    // Wrap and odd count
    build_exp(6, 3);
    run_scan("wrap3", 6, 3, 0, 0, 0, '0, 0);
    compare_words("wrap3");
    chk("wrap3_done_once", 64'(done_n), 64'(1));

    // Backpressure 1,0,0,1
    build_exp(0, 8);
    run_scan("bp", 0, 8, 1, 0, 0, '0, 0);
    compare_words("bp");

    // Edge counts
    build_exp(5, 0);
    run_scan("cnt0", 5, 0, 0, 0, 0, '0, 0);
    compare_words("cnt0");
    build_exp(3, 12);
    run_scan("cnt12", 3, 12, 0, 0, 0, '0, 0);
    compare_words("cnt12");

    // Write on the FETCH edge of pair (2,3): old value captured
    build_exp(0, 8);
    run_scan("wr_late", 0, 8, 0, 4, 2, 32'h5555_5555, 0);
    model[2] = 32'h5555_5555;
    compare_words("wr_late");
    chk("wr_late_stored", 64'(rf.regs[2]), 64'(model[2]));
    wr(2, 32'h2222_2222);
    // Same write one cycle earlier: new value captured
    build_exp(0, 8);
    exp_q[2] = {AW'(2), 32'h5555_5555};
    run_scan("wr_early", 0, 8, 0, 3, 2, 32'h5555_5555, 0);
    model[2] = 32'h5555_5555;
    compare_words("wr_early");

    // Start while busy is ignored
    build_exp(1, 6);
    run_scan("restart", 1, 6, 0, 0, 0, '0, 5);
    compare_words("restart");

    // Reset during DRAIN1 (cycle 3 after start with ready high)
    first_reg = AW'(0);
    count     = (AW+1)'(8);
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("arst_pre_valid", 64'(stream_if.out_valid), 64'(1));
    chk("arst_pre_addr", 64'(stream_if.out_addr), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(stream_if.out_valid), 64'(0));
    chk("arst_addr", 64'(stream_if.out_addr), 64'(0));
    chk("arst_data", 64'(stream_if.out_data), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_rr1", 64'(read_reg1), 64'(0));
    chk("arst_rr2", 64'(read_reg2), 64'(0));
    step();
    chk("arst_done_hold", 64'(done), 64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    step();
    chk("arst_idle_done", 64'(done), 64'(0));

    // Randomized scans against the model
    for (int t = 0; t < 8; t++) begin
      int f;
      int n;
      int m;
      for (int k = 0; k < 3; k++) wr(int'($urandom_range(0, NR - 1)), $urandom);
      f = int'($urandom_range(0, NR - 1));
      n = int'($urandom_range(0, 15));
      m = (t % 2 == 0) ? 2 : 0;
      build_exp(f, n);
      run_scan($sformatf("rnd%0d", t), f, n, m, 0, 0, '0, 0);
      compare_words($sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_scan_reader.md
# reg_scan_reader

Sequential read-side master for the 8×32 register file (two asynchronous read ports, 3-bit addresses). On a start pulse it walks a contiguous, wrapping range of registers two at a time through read ports 1 and 2. It emits each register as an {address, data} word on a valid/ready stream. It sits between the register file and debug/trace logic, giving hardware the register-dump view that a bench otherwise gets by writing the array to a file.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 3, register address width
- NUM_REGS, 8, registers in the file (2**ADDR_W)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE
- first_reg  in  ADDR_W  first register of the scan, sampled with start
- count  in  ADDR_W+1  registers to scan, sampled with start; 0 gives an empty scan, values >NUM_REGS clamp to NUM_REGS
- read_reg1  out  ADDR_W  to register file read port 1
- read_reg2  out  ADDR_W  to register file read port 2
- read_data1  in  DATA_W  from register file, combinational on read_reg1
- read_data2  in  DATA_W  from register file, combinational on read_reg2
- out_valid  out  1  stream word valid
- out_ready  in  1  downstream accepts
- out_addr  out  ADDR_W  register index of the current word
- out_data  out  DATA_W  register contents
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at scan end

## Operation
- States are IDLE, FETCH, DRAIN0, DRAIN1 and FIN.
- IDLE → FETCH when start is high:
  - latch cur = first_reg;
  - latch rem = min(count, NUM_REGS).
- An empty scan (rem 0) goes IDLE → FIN instead.
- FETCH lasts one cycle:
  - read_reg1 = cur, read_reg2 = cur+1 mod NUM_REGS;
  - capture read_data1/2 into buffers b0/b1 at the closing edge;
  - go to DRAIN0 with out_valid=1, out_addr=cur, out_data=b0.
- DRAIN0, on a handshake (out_valid && out_ready):
  - if rem==1 → FIN;
  - otherwise present b1 with addr cur+1 and go to DRAIN1.
- DRAIN1, on a handshake:
  - cur += 2 mod NUM_REGS, rem -= 2;
  - if rem is now 0 → FIN, otherwise → FETCH.
- rem decrements only on handshakes (1 in DRAIN0 when it ends the scan, else 2 at the end of DRAIN1). Width is ADDR_W+1 and it never underflows.
- FIN: done=1 for one cycle, busy=0, → IDLE.
- Addresses wrap modulo NUM_REGS. A scan of 8 starting at 6 emits 6,7,0,1,…,5.
- Data is sampled per pair at its FETCH edge. A register-file write on that same edge is not seen, because the old value is captured.
- start while not IDLE is ignored, with no queueing.
- read_reg1/read_reg2 hold their last value outside FETCH.

## Timing
- Reset values, all asynchronous: state IDLE, busy 0, done 0, out_valid 0, out_addr 0, out_data 0, read_reg1 0, read_reg2 0, cur 0, rem 0, b0/b1 0.
- Reset asserted mid-scan aborts immediately. There is no done pulse and the stream word is dropped.
- Latency:
  - start at edge N → FETCH during cycle N+1;
  - first out_valid in cycle N+2;
  - empty scan gives a done pulse in cycle N+1.
- With out_ready tied high, throughput is 2 words per 3 cycles. An 8-register scan therefore has out_valid high 8 of 12 cycles, and done in the cycle after the last handshake.
- Stream rules:
  - out_valid/out_addr/out_data stay stable while out_valid && !out_ready;
  - out_valid never drops without a handshake;
  - out_valid is deasserted in FETCH and FIN.
- busy = (state != IDLE && state != FIN).

## Structure
- Shared package reg_scan_pkg:
  - state enum (IDLE, FETCH, DRAIN0, DRAIN1, FIN);
  - constants DATA_W=32, ADDR_W=3, NUM_REGS=8, shared with the register file.
- Single module, no sub-module. The 2-entry capture buffer and FSM are small enough to stay inline.
- The bench instantiates the real register file and connects it to read_reg1/2 and read_data1/2.

## Test plan
- **Full scan:** preload reg[i]=32'h1111_1111*i; start, first_reg=0, count=8, out_ready=1 → words (0,0x0)…(7,0x7777_7777) in order; done 12 cycles after the first FETCH.
- **Wrap and odd count:** first_reg=6, count=3 → addrs 6,7,0 with matching data; DRAIN1 is skipped after the single-word pair; done once.
- **Backpressure:** out_ready toggling 1,0,0,1 → each word holds stable while stalled; no loss or duplication; 8 words total.
- **Edge counts:** count=0 → done in cycle N+1, no out_valid; count=12 → exactly 8 words.
- **Concurrent write:** write reg[2]=32'h5555_5555 on the FETCH edge of pair (2,3) → old reg[2] is emitted. The same write one cycle earlier → 0x5555_5555 is emitted.
- **Reset and start-while-busy:** rst_n low during DRAIN1 → all outputs 0 and IDLE, no done. A second start mid-scan → ignored, the word sequence is unchanged.
